// File: rtl/matrix_zigzag_serializer.sv
// Captures one 8x8 matrix of 32-bit words and streams it out in JPEG zigzag
// (or raster) order over a valid/ready handshake, with back-to-back reload.
module matrix_zigzag_serializer #(
    parameter int ZIGZAG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          validin,
    input  logic [2047:0] matrix,
    input  logic          ready,
    output logic [31:0]   dout,
    output logic          validout,
    output logic          last,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [5:0] ZZ_TAB [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [5:0] ord_f(input logic [5:0] i);
        return (ZIGZAG != 0) ? ZZ_TAB[i] : i;
    endfunction

    state_t          state, state_n;
    logic [5:0]      idx, idx_n;
    logic [2047:0]   mbuf;
    logic            load;
    logic [31:0]     dout_n;
    logic            last_n;
    logic            overrun_n;

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        load      = 1'b0;
        overrun_n = overrun;
        unique case (state)
            IDLE: begin
                if (validin) begin
                    load    = 1'b1;
                    idx_n   = 6'd0;
                    state_n = STREAM;
                end
            end
            STREAM: begin
                if (ready) begin
                    if (idx == 6'd63) begin
                        idx_n = 6'd0;
                        if (validin) load = 1'b1;
                        else         state_n = IDLE;
                    end else begin
                        idx_n = idx + 6'd1;
                    end
                end
                // Only the final handshake may accept a new block
                if (validin && !(ready && idx == 6'd63)) overrun_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output word is looked up one cycle ahead so dout is a plain register
    always_comb begin
        dout_n = dout;
        if (load)
            dout_n = matrix[{ord_f(6'd0), 5'd0} +: 32];
        else if (state_n == STREAM)
            dout_n = mbuf[{ord_f(idx_n), 5'd0} +: 32];
        last_n = (state_n == STREAM) && (idx_n == 6'd63);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 6'd0;
            dout    <= 32'd0;
            last    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            dout    <= dout_n;
            last    <= last_n;
            overrun <= overrun_n;
        end
    end

    always_ff @(posedge clk) begin
        if (load) mbuf <= matrix;
    end

    assign validout = (state == STREAM);
    assign busy     = (state == STREAM);

endmodule

// File: tb/tb_matrix_zigzag_serializer.sv
// Randomized bench: zigzag and raster instances share stimulus and are checked
// against a queue-based model of the expected word stream.
module tb_matrix_zigzag_serializer;

    logic          clk = 1'b0;
    logic          rst, validin, ready;
    logic [2047:0] mat;
    logic [31:0]   dout_z, dout_r;
    logic          vo_z, vo_r, last_z, last_r, busy_z, busy_r, ovr_z, ovr_r;

    matrix_zigzag_serializer #(.ZIGZAG(1)) dut_z (
        .clk(clk), .rst(rst), .validin(validin), .matrix(mat), .ready(ready),
        .dout(dout_z), .validout(vo_z), .last(last_z), .busy(busy_z), .overrun(ovr_z));

    matrix_zigzag_serializer #(.ZIGZAG(0)) dut_r (
        .clk(clk), .rst(rst), .validin(validin), .matrix(mat), .ready(ready),
        .dout(dout_r), .validout(vo_r), .last(last_r), .busy(busy_r), .overrun(ovr_r));

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          zz [64];
    logic [31:0] q_zz[$];
    logic [31:0] q_rs[$];
    int          pos = 0;
    bit          ovr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Zigzag order from the diagonal-walk rule: even diagonals run bottom-up
    task automatic build_zigzag();
        int n = 0;
        for (int s = 0; s <= 14; s++) begin
            int rlo = (s > 7) ? s - 7 : 0;
            int rhi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = rhi; r >= rlo; r--) begin zz[n] = 8 * r + (s - r); n++; end
            end else begin
                for (int r = rlo; r <= rhi; r++) begin zz[n] = 8 * r + (s - r); n++; end
            end
        end
    endtask

    task automatic push_block(input logic [2047:0] m);
        for (int i = 0; i < 64; i++) begin
            q_zz.push_back(m[32 * zz[i] +: 32]);
            q_rs.push_back(m[32 * i +: 32]);
        end
    endtask

    // Check outputs against the model, then advance model and DUT one clock
    task automatic step();
        int n;
        bit hs;
        check("zz_vld",  32'(vo_z),   32'(q_zz.size() != 0));
        check("zz_busy", 32'(busy_z), 32'(q_zz.size() != 0));
        check("zz_ovr",  32'(ovr_z),  32'(ovr));
        check("rs_vld",  32'(vo_r),   32'(q_rs.size() != 0));
        check("rs_ovr",  32'(ovr_r),  32'(ovr));
        if (q_zz.size() != 0) begin
            check("zz_dout", dout_z, q_zz[0]);
            check("rs_dout", dout_r, q_rs[0]);
            check("zz_last", 32'(last_z), 32'(pos == 63));
            check("rs_last", 32'(last_r), 32'(pos == 63));
        end else begin
            check("zz_last_idle", 32'(last_z), 32'd0);
            check("rs_last_idle", 32'(last_r), 32'd0);
        end
        n  = q_zz.size();
        hs = (n != 0) && ready;
        if (rst) begin
            q_zz.delete(); q_rs.delete(); pos = 0; ovr = 0;
        end else begin
            if (hs) begin
                void'(q_zz.pop_front()); void'(q_rs.pop_front()); pos++;
            end
            if (validin) begin
                if (n == 0 || (hs && n == 1)) begin push_block(mat); pos = 0; end
                else ovr = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int k = 0; k < 64; k++) mat[32 * k +: 32] = base + 32'(k);
    endtask

    task automatic start_block(input logic [31:0] base);
        fill(base);
        validin = 1'b1; ready = 1'b1;
        step();
        validin = 1'b0;
    endtask

    task automatic drain(input int budget, input bit rnd);
        int c = 0;
        while (q_zz.size() != 0 && c < budget) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            c++;
        end
        check("drain_done", 32'(q_zz.size()), 32'd0);
        ready = 1'b0;
        step();
    endtask

    task automatic run_to_pos(input int p);
        int c = 0;
        ready = 1'b1;
        while (pos < p && q_zz.size() != 0 && c < 200) begin step(); c++; end
        check("reach_pos", 32'(pos), 32'(p));
    endtask

    initial begin
        build_zigzag();
        rst = 1'b1; validin = 1'b0; ready = 1'b0; mat = '0;
        @(posedge clk);
        #1;
        step();
        check("rst_dout_z", dout_z, 32'd0);
        check("rst_dout_r", dout_r, 32'd0);
        rst = 1'b0;
        step();

        // zigzag sequence with identity data, then raster data pattern
        start_block(32'd0);
        check("first_word", dout_z, 32'd0);
        drain(100, 0);
        start_block(32'h3f350481);
        drain(100, 0);

        // backpressure
        start_block(32'd0);
        drain(400, 1);

        // back-to-back reload on the last handshake
        start_block(32'd0);
        run_to_pos(63);
        fill(32'd100);
        validin = 1'b1; ready = 1'b1;
        step();
        validin = 1'b0;
        check("b2b_first", dout_z, 32'd100);
        check("b2b_vld", 32'(vo_z), 32'd1);
        drain(100, 0);

        // dropped validin mid-block
        start_block(32'd0);
        run_to_pos(10);
        fill(32'd500);
        validin = 1'b1;
        step();
        validin = 1'b0;
        check("ovr_set", 32'(ovr_z), 32'd1);
        drain(100, 0);
        check("ovr_sticky", 32'(ovr_z), 32'd1);

        // reset mid-stream
        start_block(32'd0);
        run_to_pos(30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_vld",  32'(vo_z),   32'd0);
        check("mrst_busy", 32'(busy_z), 32'd0);
        check("mrst_last", 32'(last_z), 32'd0);
        check("mrst_ovr",  32'(ovr_z),  32'd0);
        start_block(32'd7000);
        check("restart_word", dout_z, 32'd7000);
        drain(100, 0);

        // random traffic, including illegal validin pulses
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 64; k++) mat[32 * k +: 32] = $urandom();
            ready   = 1'($urandom_range(0, 3) != 0);
            validin = ($urandom_range(0, 15) == 0);
            step();
        end
        validin = 1'b0;
        drain(400, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
